// File: rtl/udt_tx_arbiter.sv
// Packet-boundary arbiter sharing the UDP tx stream between UDT control and data sources.
// Optional statistics counters: define UDT_TX_ARB_STATS_EN.
module udt_tx_arbiter #(
    parameter int DATA_W         = 64,
    parameter int MAX_CTRL_BURST = 4
) (
    input  logic                core_clk,
    input  logic                core_rst,
    input  logic                ctrl_tvalid,
    output logic                ctrl_tready,
    input  logic [DATA_W-1:0]   ctrl_tdata,
    input  logic [DATA_W/8-1:0] ctrl_tkeep,
    input  logic                ctrl_tlast,
    input  logic                data_tvalid,
    output logic                data_tready,
    input  logic [DATA_W-1:0]   data_tdata,
    input  logic [DATA_W/8-1:0] data_tkeep,
    input  logic                data_tlast,
    output logic                m_tvalid,
    input  logic                m_tready,
    output logic [DATA_W-1:0]   m_tdata,
    output logic [DATA_W/8-1:0] m_tkeep,
    output logic                m_tlast,
    output logic                m_tsrc,
    output logic                busy
`ifdef UDT_TX_ARB_STATS_EN
    ,
    output logic [31:0]         ctrl_pkt_cnt,
    output logic [31:0]         data_pkt_cnt,
    output logic [31:0]         stall_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        CTRL,
        DATA
    } state_t;

    localparam logic [3:0] MAX_RUN = 4'(MAX_CTRL_BURST);

    state_t     state_q, state_d;
    logic [3:0] run_q, run_d;
    logic       ctrl_win;

    assign ctrl_win = ctrl_tvalid && (!data_tvalid || run_q < MAX_RUN);

    always_comb begin
        state_d     = state_q;
        run_d       = run_q;
        ctrl_tready = 1'b0;
        data_tready = 1'b0;
        m_tvalid    = 1'b0;
        m_tdata     = '0;
        m_tkeep     = '0;
        m_tlast     = 1'b0;
        m_tsrc      = 1'b0;
        busy        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ctrl_win) begin
                    state_d = CTRL;
                    if (run_q != MAX_RUN) begin
                        run_d = run_q + 4'd1;
                    end
                end else if (data_tvalid) begin
                    state_d = DATA;
                    run_d   = '0;
                end
            end
            CTRL: begin
                busy        = 1'b1;
                ctrl_tready = m_tready;
                m_tvalid    = ctrl_tvalid;
                m_tdata     = ctrl_tdata;
                m_tkeep     = ctrl_tkeep;
                m_tlast     = ctrl_tlast;
                if (ctrl_tvalid && m_tready && ctrl_tlast) begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                busy        = 1'b1;
                m_tsrc      = 1'b1;
                data_tready = m_tready;
                m_tvalid    = data_tvalid;
                m_tdata     = data_tdata;
                m_tkeep     = data_tkeep;
                m_tlast     = data_tlast;
                if (data_tvalid && m_tready && data_tlast) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            state_q <= IDLE;
            run_q   <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
        end
    end

`ifdef UDT_TX_ARB_STATS_EN
    logic [31:0] ctrl_pkt_cnt_q, ctrl_pkt_cnt_d;
    logic [31:0] data_pkt_cnt_q, data_pkt_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        ctrl_pkt_cnt_d = ctrl_pkt_cnt_q;
        data_pkt_cnt_d = data_pkt_cnt_q;
        stall_cnt_d    = stall_cnt_q;
        if (m_tvalid && m_tready && m_tlast) begin
            if (m_tsrc) begin
                data_pkt_cnt_d = data_pkt_cnt_q + 32'd1;
            end else begin
                ctrl_pkt_cnt_d = ctrl_pkt_cnt_q + 32'd1;
            end
        end
        // Stall count saturates; packet counts wrap
        if (m_tvalid && !m_tready && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            ctrl_pkt_cnt_q <= '0;
            data_pkt_cnt_q <= '0;
            stall_cnt_q    <= '0;
        end else begin
            ctrl_pkt_cnt_q <= ctrl_pkt_cnt_d;
            data_pkt_cnt_q <= data_pkt_cnt_d;
            stall_cnt_q    <= stall_cnt_d;
        end
    end

    assign ctrl_pkt_cnt = ctrl_pkt_cnt_q;
    assign data_pkt_cnt = data_pkt_cnt_q;
    assign stall_cnt    = stall_cnt_q;
`endif

endmodule

// File: tb/tb_udt_tx_arbiter.sv
// Scoreboard bench for udt_tx_arbiter: directed packets, expected beats tagged with cycle.
// Statistics checks compile in when UDT_TX_ARB_STATS_EN is defined.
module tb_udt_tx_arbiter;

    logic        core_clk = 1'b0;
    logic        core_rst = 1'b1;
    logic        ctrl_tvalid, ctrl_tready, ctrl_tlast;
    logic [63:0] ctrl_tdata;
    logic [7:0]  ctrl_tkeep;
    logic        data_tvalid, data_tready, data_tlast;
    logic [63:0] data_tdata;
    logic [7:0]  data_tkeep;
    logic        m_tvalid, m_tready, m_tlast, m_tsrc, busy;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
`ifdef UDT_TX_ARB_STATS_EN
    logic [31:0] ctrl_pkt_cnt, data_pkt_cnt, stall_cnt;
    logic [31:0] s0;
`endif

    udt_tx_arbiter #(.DATA_W(64), .MAX_CTRL_BURST(4)) dut (
        .core_clk(core_clk), .core_rst(core_rst),
        .ctrl_tvalid(ctrl_tvalid), .ctrl_tready(ctrl_tready),
        .ctrl_tdata(ctrl_tdata), .ctrl_tkeep(ctrl_tkeep), .ctrl_tlast(ctrl_tlast),
        .data_tvalid(data_tvalid), .data_tready(data_tready),
        .data_tdata(data_tdata), .data_tkeep(data_tkeep), .data_tlast(data_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
        .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tsrc(m_tsrc), .busy(busy)
`ifdef UDT_TX_ARB_STATS_EN
        , .ctrl_pkt_cnt(ctrl_pkt_cnt), .data_pkt_cnt(data_pkt_cnt),
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 core_clk = ~core_clk;

    typedef struct packed {
        logic [63:0] d;
        logic        l;
    } beat_t;

    typedef struct packed {
        logic [63:0] d;
        logic        l;
        logic        s;
        logic [31:0] c;
    } exp_t;

    beat_t       cq[$];
    beat_t       dq[$];
    exp_t        eq[$];
    exp_t        e;
    int          tests = 0;
    int          fails = 0;
    logic [31:0] ncyc  = 0;
    logic [31:0] n;
    bit          c_hs, d_hs;
    bit          ctrl_en = 1'b1;
    bit          data_en = 1'b1;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    // Monitor: counts cycles, records source handshakes, checks every output beat
    always @(negedge core_clk) begin
        ncyc++;
        c_hs = ctrl_tvalid && ctrl_tready;
        d_hs = data_tvalid && data_tready;
        if (m_tvalid && m_tready) begin
            tests++;
            if (eq.size() == 0) begin
                fails++;
                $display("FAIL beat: unexpected d=%h src=%b cyc=%0d",
                         m_tdata, m_tsrc, ncyc);
            end else begin
                e = eq.pop_front();
                if ({m_tdata, m_tlast, m_tsrc, ncyc} !== e || m_tkeep !== e.d[7:0]) begin
                    fails++;
                    $display("FAIL beat: got d=%h k=%h l=%b s=%b c=%0d want d=%h l=%b s=%b c=%0d",
                             m_tdata, m_tkeep, m_tlast, m_tsrc, ncyc, e.d, e.l, e.s, e.c);
                end
            end
        end
    end

    task automatic drive();
        ctrl_tvalid = ctrl_en && cq.size() != 0;
        ctrl_tdata  = (cq.size() != 0) ? cq[0].d : 64'd0;
        ctrl_tlast  = (cq.size() != 0) ? cq[0].l : 1'b0;
        ctrl_tkeep  = ctrl_tdata[7:0];
        data_tvalid = data_en && dq.size() != 0;
        data_tdata  = (dq.size() != 0) ? dq[0].d : 64'd0;
        data_tlast  = (dq.size() != 0) ? dq[0].l : 1'b0;
        data_tkeep  = data_tdata[7:0];
    endtask

    task automatic cyc();
        @(posedge core_clk);
        #1;
        if (c_hs) void'(cq.pop_front());
        if (d_hs) void'(dq.pop_front());
        c_hs = 1'b0;
        d_hs = 1'b0;
        drive();
    endtask

    task automatic pc(logic [63:0] d, logic l);
        cq.push_back('{d: d, l: l});
    endtask

    task automatic pd(logic [63:0] d, logic l);
        dq.push_back('{d: d, l: l});
    endtask

    task automatic ex(logic [63:0] d, logic l, logic s, logic [31:0] c);
        eq.push_back('{d: d, l: l, s: s, c: c});
    endtask

    task automatic drain(string nm);
        int k = 0;
        while (eq.size() != 0 && k < 60) begin
            cyc();
            k++;
        end
        tests++;
        if (eq.size() != 0) begin
            fails++;
            $display("FAIL %s_drain: %0d beats missing, want 0", nm, eq.size());
            eq.delete();
        end
    endtask

    task automatic idle_outs(string nm);
        chk(nm, {56'd0, m_tvalid, m_tlast, m_tsrc, busy, ctrl_tready, data_tready, 2'b00}, 64'd0);
        chk({nm, "_data"}, {m_tdata[55:0], m_tkeep}, 64'd0);
    endtask

    initial begin
        m_tready = 1'b1;
        drive();
        repeat (2) cyc();
        idle_outs("reset");
`ifdef UDT_TX_ARB_STATS_EN
        chk("reset_cnt", {32'd0, ctrl_pkt_cnt | data_pkt_cnt | stall_cnt}, 64'd0);
`endif
        core_rst = 1'b0;
        cyc();

        // 3-beat ctrl packet, first beat one cycle after request
        n = ncyc;
        pc(64'hA1, 0); pc(64'hA2, 0); pc(64'hA3, 1);
        drive();
        ex(64'hA1, 0, 0, n + 2); ex(64'hA2, 0, 0, n + 3); ex(64'hA3, 1, 0, n + 4);
        drain("ctrl3");
        chk("ctrl3_busy", {63'd0, busy}, 64'd0);
        cyc();

        // Fresh burst counter, both sources always valid, single-beat packets
        core_rst = 1'b1;
        cyc();
        core_rst = 1'b0;
        n = ncyc;
        for (int i = 0; i < 8; i++) pc(64'hC0 + 64'(i), 1);
        pd(64'hD0, 1); pd(64'hD1, 1);
        drive();
        for (int i = 0; i < 4; i++) ex(64'hC0 + 64'(i), 1, 0, n + 2 + 32'(2 * i));
        ex(64'hD0, 1, 1, n + 10);
        for (int i = 0; i < 4; i++) ex(64'hC4 + 64'(i), 1, 0, n + 12 + 32'(2 * i));
        ex(64'hD1, 1, 1, n + 20);
        drain("burst");
        cyc();

        // Data packet is not pre-empted by ctrl arriving mid-packet
        n = ncyc;
        for (int i = 0; i < 4; i++) pd(64'hE0 + 64'(i), i == 3);
        drive();
        for (int i = 0; i < 4; i++) ex(64'hE0 + 64'(i), i == 3, 1, n + 2 + 32'(i));
        ex(64'hF0, 0, 0, n + 7); ex(64'hF1, 1, 0, n + 8);
        cyc(); cyc();
        pc(64'hF0, 0); pc(64'hF1, 1);
        drive();
        drain("nopreempt");
        cyc();

        // Back-pressure for 5 cycles mid data packet
        n = ncyc;
        pd(64'h60, 0); pd(64'h61, 0); pd(64'h62, 1);
        drive();
        ex(64'h60, 0, 1, n + 2);
        cyc(); cyc();
`ifdef UDT_TX_ARB_STATS_EN
        s0 = stall_cnt;
`endif
        m_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("stall_rdy", {63'd0, data_tready}, 64'd0);
            chk("stall_hold", m_tdata, 64'h61);
        end
        m_tready = 1'b1;
        ex(64'h61, 0, 1, n + 8); ex(64'h62, 1, 1, n + 9);
        drain("stall");
`ifdef UDT_TX_ARB_STATS_EN
        chk("stall_cnt", {32'd0, stall_cnt}, {32'd0, s0 + 32'd5});
`endif
        cyc();

        // Grant lock: ctrl pauses tvalid, pending data must wait
        n = ncyc;
        pc(64'h70, 0); pc(64'h71, 1); pd(64'h80, 1);
        drive();
        ex(64'h70, 0, 0, n + 2); ex(64'h71, 1, 0, n + 6); ex(64'h80, 1, 1, n + 8);
        cyc(); cyc();
        ctrl_en = 1'b0;
        drive();
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("lock", {61'd0, busy, m_tsrc, data_tready}, 64'h4);
        end
        ctrl_en = 1'b1;
        drive();
        drain("lock");
        cyc();

        // Reset on beat 2 of a ctrl packet, then a clean re-grant
        n = ncyc;
        pc(64'h90, 0); pc(64'h91, 0); pc(64'h92, 1);
        drive();
        ex(64'h90, 0, 0, n + 2);
        cyc(); cyc();
        m_tready = 1'b0;
        core_rst = 1'b1;
        cyc();
        m_tready = 1'b1;
        idle_outs("midrst");
        core_rst = 1'b0;
        cq.delete();
        drive();
        n = ncyc;
        pc(64'hB0, 0); pc(64'hB1, 1);
        drive();
        ex(64'hB0, 0, 0, n + 2); ex(64'hB1, 1, 0, n + 3);
        drain("regrant");
`ifdef UDT_TX_ARB_STATS_EN
        chk("regrant_cnt", {32'd0, ctrl_pkt_cnt}, 64'd1);
        cyc();

        // Packet counter wrap
        s0 = data_pkt_cnt;
        force dut.ctrl_pkt_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.ctrl_pkt_cnt_q;
        n = ncyc;
        pc(64'hCC, 1);
        drive();
        ex(64'hCC, 1, 0, n + 2);
        drain("wrap");
        chk("wrap_ctrl", {32'd0, ctrl_pkt_cnt}, 64'd0);
        chk("wrap_data", {32'd0, data_pkt_cnt}, {32'd0, s0});
`endif
        cyc();
        tests++;
        if (eq.size() != 0) begin
            fails++;
            $display("FAIL leftover: got %0d beats want 0", eq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
